// File: rtl/sprite_blitter_if.sv
// Bus bundle between the sprite blitter and its neighbours: draw-queue head
// and pop strobe, sprite memory read port and framebuffer write port.
// The master modport is the blitter side; the slave modport is the peer side.
interface sprite_blitter_if #(
   parameter int SPRITE_ADDR_SIZE = 13,
   parameter int FB_ADDR_W        = 17
) ();
   // draw queue
   logic                      is_empty;
   logic                      dequeue;
   logic [7:0]                sprite_id;
   logic [15:0]               sprite_x;
   logic [15:0]               sprite_y;
   logic [7:0]                sprite_scale;
   // sprite memory read port
   logic                      sprite_r_en;
   logic [SPRITE_ADDR_SIZE:0] sprite_r_addr;
   logic [3:0]                sprite_r_data;
   // framebuffer write port
   logic                      fb_w_en;
   logic                      fb_w_ready;
   logic [FB_ADDR_W-1:0]      fb_w_addr;
   logic [3:0]                fb_w_data;

   modport master (
      input  is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
      input  sprite_r_data, fb_w_ready,
      output dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data
   );

   modport slave (
      output is_empty, sprite_id, sprite_x, sprite_y, sprite_scale,
      output sprite_r_data, fb_w_ready,
      input  dequeue, sprite_r_en, sprite_r_addr, fb_w_en, fb_w_addr, fb_w_data
   );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: pops draw commands one at a time, reads the referenced
// 32x32 4-bit sprite and writes the scaled, clipped pixels to the framebuffer.
// Each destination pixel costs READ -> WAIT -> WRITE (3 cycles without stalls).
// Optional feature macro: SPRITE_TRANSPARENCY_EN -- when defined, colour
// index 0 is transparent and never written.
module sprite_blitter #(
   parameter int SPRITE_ADDR_SIZE = 13,
   parameter int FB_WIDTH         = 320,
   parameter int FB_HEIGHT        = 240,
   parameter int FB_ADDR_W        = 17,
   parameter int MAX_SCALE        = 4
) (
   input  logic               sys_clock,
   input  logic               sys_reset_n,
   input  logic               enable,
   sprite_blitter_if.master   bus,
   output logic               busy,
   output logic [15:0]        draws_done
);
   localparam int ID_BITS = SPRITE_ADDR_SIZE + 1 - 10;
   localparam logic signed [16:0] FB_W_S = 17'(FB_WIDTH);
   localparam logic signed [16:0] FB_H_S = 17'(FB_HEIGHT);

   typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
   state_t state_reg;

   // latched command and scan position
   logic [ID_BITS-1:0]  id_reg;
   logic signed [16:0]  x_reg;      // left edge, reloaded into px at each row start
   logic signed [16:0]  px_reg;
   logic signed [16:0]  py_reg;
   logic [7:0]          scale_reg;
   logic [7:0]          subx_reg;   // repeats of the current source column
   logic [7:0]          suby_reg;   // repeats of the current source row
   logic [4:0]          scol_reg;
   logic [4:0]          srow_reg;

   // next-pixel values
   logic [7:0]          scale_eff;
   logic                row_end;
   logic                last_pix;
   logic [7:0]          subx_next;
   logic [7:0]          suby_next;
   logic [4:0]          scol_next;
   logic [4:0]          srow_next;
   logic signed [16:0]  px_next;
   logic signed [16:0]  py_next;
   logic                visible;
   logic                opaque;
   logic [FB_ADDR_W-1:0] addr_calc;

   // clamp the queued scale into 1..MAX_SCALE
   always_comb begin
      scale_eff = bus.sprite_scale;
      if (bus.sprite_scale == 8'd0)
         scale_eff = 8'd1;
      else if (bus.sprite_scale > 8'(MAX_SCALE))
         scale_eff = 8'(MAX_SCALE);
   end

   // row-major scan advance; sub-counters replace a divide by the scale
   always_comb begin
      row_end   = (scol_reg == 5'd31) && (subx_reg == scale_reg - 8'd1);
      last_pix  = row_end && (srow_reg == 5'd31) && (suby_reg == scale_reg - 8'd1);
      subx_next = subx_reg + 8'd1;
      scol_next = scol_reg;
      px_next   = px_reg + 17'sd1;
      suby_next = suby_reg;
      srow_next = srow_reg;
      py_next   = py_reg;
      if (subx_reg == scale_reg - 8'd1) begin
         subx_next = 8'd0;
         scol_next = scol_reg + 5'd1;
      end
      if (row_end) begin
         subx_next = 8'd0;
         scol_next = 5'd0;
         px_next   = x_reg;
         py_next   = py_reg + 17'sd1;
         suby_next = suby_reg + 8'd1;
         if (suby_reg == scale_reg - 8'd1) begin
            suby_next = 8'd0;
            srow_next = srow_reg + 5'd1;
         end
      end
   end

   // clipping, transparency and framebuffer address of the current pixel
   always_comb begin
      visible   = (px_reg >= 17'sd0) && (px_reg < FB_W_S) &&
                  (py_reg >= 17'sd0) && (py_reg < FB_H_S);
`ifdef SPRITE_TRANSPARENCY_EN
      opaque    = (bus.sprite_r_data != 4'd0);
`else
      opaque    = 1'b1;
`endif
      addr_calc = FB_ADDR_W'(py_reg[15:0]) * FB_ADDR_W'(FB_WIDTH) + FB_ADDR_W'(px_reg[15:0]);
   end

   // command FSM with registered outputs
   always_ff @(posedge sys_clock or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_reg         <= IDLE;
         id_reg            <= '0;
         x_reg             <= '0;
         px_reg            <= '0;
         py_reg            <= '0;
         scale_reg         <= 8'd1;
         subx_reg          <= '0;
         suby_reg          <= '0;
         scol_reg          <= '0;
         srow_reg          <= '0;
         bus.dequeue       <= 1'b0;
         bus.sprite_r_en   <= 1'b0;
         bus.sprite_r_addr <= '0;
         bus.fb_w_en       <= 1'b0;
         bus.fb_w_addr     <= '0;
         bus.fb_w_data     <= '0;
         busy              <= 1'b0;
         draws_done        <= 16'd0;
      end else begin
         bus.dequeue     <= 1'b0;
         bus.sprite_r_en <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (enable && !bus.is_empty) begin
                  bus.dequeue       <= 1'b1;
                  busy              <= 1'b1;
                  id_reg            <= bus.sprite_id[ID_BITS-1:0];
                  x_reg             <= {bus.sprite_x[15], bus.sprite_x};
                  px_reg            <= {bus.sprite_x[15], bus.sprite_x};
                  py_reg            <= {bus.sprite_y[15], bus.sprite_y};
                  scale_reg         <= scale_eff;
                  subx_reg          <= '0;
                  suby_reg          <= '0;
                  scol_reg          <= '0;
                  srow_reg          <= '0;
                  bus.sprite_r_en   <= 1'b1;
                  bus.sprite_r_addr <= {bus.sprite_id[ID_BITS-1:0], 10'd0};
                  state_reg         <= READ;
               end
            end
            READ: state_reg <= WAIT;
            WAIT: begin
               if (visible && opaque) begin
                  bus.fb_w_en   <= 1'b1;
                  bus.fb_w_addr <= addr_calc;
                  bus.fb_w_data <= bus.sprite_r_data;
               end
               state_reg <= WRITE;
            end
            WRITE: begin
               if (!bus.fb_w_en || bus.fb_w_ready) begin
                  bus.fb_w_en <= 1'b0;
                  subx_reg    <= subx_next;
                  suby_reg    <= suby_next;
                  scol_reg    <= scol_next;
                  srow_reg    <= srow_next;
                  px_reg      <= px_next;
                  py_reg      <= py_next;
                  if (last_pix) begin
                     state_reg <= DONE;
                  end else begin
                     bus.sprite_r_en   <= 1'b1;
                     bus.sprite_r_addr <= {id_reg, srow_next, scol_next};
                     state_reg         <= READ;
                  end
               end
            end
            DONE: begin
               draws_done <= draws_done + 16'd1;
               busy       <= 1'b0;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: command queue and sprite memory models,
// scoreboard of expected framebuffer writes built from a direct model.
module tb_sprite_blitter;
`ifdef SPRITE_TRANSPARENCY_EN
   localparam bit TRANSP = 1'b1;
`else
   localparam bit TRANSP = 1'b0;
`endif

   typedef struct {
      int         addr;
      logic [3:0] data;
   } wr_t;

   logic        sys_clock;
   logic        sys_reset_n;
   logic        enable;
   logic        busy;
   logic [15:0] draws_done;

   sprite_blitter_if #(.SPRITE_ADDR_SIZE(13), .FB_ADDR_W(17)) bus ();

   sprite_blitter #(
      .SPRITE_ADDR_SIZE(13), .FB_WIDTH(320), .FB_HEIGHT(240),
      .FB_ADDR_W(17), .MAX_SCALE(4)
   ) dut (
      .sys_clock  (sys_clock),
      .sys_reset_n(sys_reset_n),
      .enable     (enable),
      .bus        (bus),
      .busy       (busy),
      .draws_done (draws_done)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;

   // models
   logic [3:0]  mem [0:16383];
   logic [3:0]  fb_img [0:76799];
   logic [7:0]  cmd_id [0:15];
   logic [15:0] cmd_x [0:15];
   logic [15:0] cmd_y [0:15];
   logic [7:0]  cmd_s [0:15];
   int          q_head = 0;
   int          q_tail = 0;
   logic [3:0]  rd_q = 4'd0;
   logic        fb_ready_q = 1'b1;

   wr_t exp_q[$];
   int  deq_cycles[$];
   int  assert_cnt = 0;
   int  fail_cnt = 0;
   int  write_cnt = 0;
   int  deq_cnt = 0;
   int  cyc = 0;
   int  first_addr = -1;
   int  first_data = -1;
   int  last_addr = -1;
   int  stall_left = 0;
   int  stall_seen = 0;
   bit  stall_hold = 0;
   logic [16:0] hold_addr = '0;
   logic [3:0]  hold_data = '0;

   assign bus.is_empty     = (q_head == q_tail);
   assign bus.sprite_id    = cmd_id[q_head];
   assign bus.sprite_x     = cmd_x[q_head];
   assign bus.sprite_y     = cmd_y[q_head];
   assign bus.sprite_scale = cmd_s[q_head];
   assign bus.sprite_r_data = rd_q;
   assign bus.fb_w_ready   = fb_ready_q;

   // queue pops on the strobe; sprite RAM with one-cycle registered read
   always @(posedge sys_clock) begin
      if (sys_reset_n && bus.dequeue && q_head != q_tail) q_head <= q_head + 1;
      if (bus.sprite_r_en) rd_q <= mem[bus.sprite_r_addr];
   end

   task automatic push_cmd(input int id, input int x, input int y, input int scale);
      int s, px, py;
      logic [13:0] sa;
      cmd_id[q_tail] = 8'(id);
      cmd_x[q_tail]  = 16'(x);
      cmd_y[q_tail]  = 16'(y);
      cmd_s[q_tail]  = 8'(scale);
      s = (scale == 0) ? 1 : ((scale > 4) ? 4 : scale);
      for (int dy = 0; dy < 32 * s; dy++) begin
         for (int dx = 0; dx < 32 * s; dx++) begin
            px = x + dx;
            py = y + dy;
            sa = 14'((id % 16) * 1024 + (dy / s) * 32 + dx / s);
            if (px >= 0 && px < 320 && py >= 0 && py < 240 && !(TRANSP && mem[sa] == 4'd0))
               exp_q.push_back('{py * 320 + px, mem[sa]});
         end
      end
      q_tail = q_tail + 1;
   endtask

   task automatic wait_draws(input logic [15:0] target, input int budget, output bit timed_out);
      int n = 0;
      timed_out = 0;
      while (!(draws_done == target && !busy)) begin
         @(negedge sys_clock);
         n++;
         if (n > budget) begin
            timed_out = 1;
            break;
         end
      end
   endtask

   // scoreboard: pops expected writes as the framebuffer accepts them
   task automatic monitor_loop();
      wr_t e;
      forever begin
         @(negedge sys_clock);
         cyc++;
         if (sys_reset_n) begin
            if (bus.dequeue) begin
               deq_cnt++;
               deq_cycles.push_back(cyc);
            end
            if (bus.fb_w_en) begin
               if (stall_hold && write_cnt == 2) begin
                  assert_cnt++;
                  if (bus.fb_w_addr !== hold_addr || bus.fb_w_data !== hold_data) begin
                     fail_cnt++;
                     $display("FAIL stall_stable: addr %0d data %0d, required addr %0d data %0d",
                              bus.fb_w_addr, bus.fb_w_data, hold_addr, hold_data);
                  end
               end
               if (stall_left > 0 && write_cnt == 2) begin
                  if (!stall_hold) begin
                     hold_addr  = bus.fb_w_addr;
                     hold_data  = bus.fb_w_data;
                     stall_hold = 1;
                  end
                  fb_ready_q = 1'b0;
                  stall_left--;
                  stall_seen++;
               end else begin
                  fb_ready_q = 1'b1;
               end
               if (fb_ready_q) begin
                  if (write_cnt == 0) begin
                     first_addr = int'(bus.fb_w_addr);
                     first_data = int'(bus.fb_w_data);
                  end
                  last_addr = int'(bus.fb_w_addr);
                  write_cnt++;
                  if (int'(bus.fb_w_addr) < 76800) fb_img[bus.fb_w_addr] = bus.fb_w_data;
                  assert_cnt++;
                  if (exp_q.size() == 0) begin
                     fail_cnt++;
                     $display("FAIL unexpected_write: addr %0d data %0d, required no write",
                              bus.fb_w_addr, bus.fb_w_data);
                  end else begin
                     e = exp_q.pop_front();
                     if (int'(bus.fb_w_addr) !== e.addr || bus.fb_w_data !== e.data) begin
                        fail_cnt++;
                        $display("FAIL write_%0d: addr %0d data %0d, required addr %0d data %0d",
                                 write_cnt, bus.fb_w_addr, bus.fb_w_data, e.addr, e.data);
                     end
                  end
               end
            end else if (stall_hold && write_cnt == 2) begin
               assert_cnt++;
               fail_cnt++;
               $display("FAIL stall_en: fb_w_en 0, required 1 while stalled");
            end
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge sys_clock);
      assert_cnt++;
      if ({bus.dequeue, bus.sprite_r_en, bus.fb_w_en, busy} !== 4'b0 || draws_done !== 16'd0) begin
         fail_cnt++;
         $display("FAIL reset_outputs: deq/ren/wen/busy %b draws %0d, required 0000 and 0",
                  {bus.dequeue, bus.sprite_r_en, bus.fb_w_en, busy}, draws_done);
      end
      sys_reset_n = 1'b1;
      repeat (3) @(negedge sys_clock);
      assert_cnt++;
      if (busy !== 1'b0 || draws_done !== 16'd0 || bus.dequeue !== 1'b0) begin
         fail_cnt++;
         $display("FAIL reset_release: busy %b draws %0d deq %b, required 0 0 0",
                  busy, draws_done, bus.dequeue);
      end
   endtask

   // basic draw with a 5-cycle stall on the third write
   task automatic test_basic();
      bit to;
      write_cnt = 0; deq_cnt = 0; stall_left = 5; stall_seen = 0; stall_hold = 0;
      enable = 1'b1;
      push_cmd(1, 10, 20, 1);
      wait_draws(16'd1, 4000, to);
      assert_cnt++;
      if (to) begin fail_cnt++; $display("FAIL basic_timeout: draws %0d, required 1", draws_done); end
      assert_cnt++;
      if (write_cnt !== 1024) begin fail_cnt++; $display("FAIL basic_count: %0d, required 1024", write_cnt); end
      assert_cnt++;
      if (first_addr !== 6410 || first_data !== 1) begin
         fail_cnt++;
         $display("FAIL basic_first: addr %0d data %0d, required 6410 1", first_addr, first_data);
      end
      assert_cnt++;
      if (last_addr !== 16361) begin fail_cnt++; $display("FAIL basic_last: %0d, required 16361", last_addr); end
      assert_cnt++;
      if (deq_cnt !== 1) begin fail_cnt++; $display("FAIL basic_dequeue: %0d pulses, required 1", deq_cnt); end
      assert_cnt++;
      if (stall_seen !== 5) begin fail_cnt++; $display("FAIL stall_cycles: %0d, required 5", stall_seen); end
      assert_cnt++;
      if (busy !== 1'b0 || draws_done !== 16'd1) begin
         fail_cnt++;
         $display("FAIL basic_end: busy %b draws %0d, required 0 1", busy, draws_done);
      end
      stall_hold = 0;
   endtask

   task automatic test_scale();
      bit to;
      for (int i = 0; i < 76800; i++) fb_img[i] = 4'd0;
      write_cnt = 0;
      push_cmd(2, 0, 0, 2);
      wait_draws(16'd2, 13000, to);
      assert_cnt++;
      if (to || write_cnt !== 4096) begin
         fail_cnt++;
         $display("FAIL scale2_count: %0d timeout %b, required 4096", write_cnt, to);
      end
      assert_cnt++;
      if (fb_img[0] !== 4'd1 || fb_img[1] !== 4'd1 || fb_img[320] !== 4'd1 || fb_img[321] !== 4'd1) begin
         fail_cnt++;
         $display("FAIL scale2_block: %0d %0d %0d %0d, required 1 1 1 1",
                  fb_img[0], fb_img[1], fb_img[320], fb_img[321]);
      end
   endtask

   task automatic test_clip();
      bit to;
      write_cnt = 0;
      push_cmd(1, -16, 230, 1);
      wait_draws(16'd3, 3500, to);
      assert_cnt++;
      if (to || write_cnt !== 160) begin
         fail_cnt++;
         $display("FAIL clip_count: %0d timeout %b, required 160", write_cnt, to);
      end
      assert_cnt++;
      if (first_addr !== 73600) begin fail_cnt++; $display("FAIL clip_first: %0d, required 73600", first_addr); end
   endtask

   // scale 0 then scale 9 queued together
   task automatic test_back_to_back();
      bit to;
      write_cnt = 0; deq_cnt = 0; deq_cycles.delete();
      push_cmd(3, 5, 7, 0);
      push_cmd(1, 0, 0, 9);
      wait_draws(16'd4, 4000, to);
      assert_cnt++;
      if (to || write_cnt !== 1024) begin
         fail_cnt++;
         $display("FAIL scale0_count: %0d timeout %b, required 1024", write_cnt, to);
      end
      wait_draws(16'd5, 52000, to);
      assert_cnt++;
      if (to || write_cnt !== 17408) begin
         fail_cnt++;
         $display("FAIL scale9_count: %0d timeout %b, required 17408", write_cnt, to);
      end
      assert_cnt++;
      if (deq_cnt !== 2) begin fail_cnt++; $display("FAIL b2b_dequeue: %0d pulses, required 2", deq_cnt); end
      else begin
         assert_cnt++;
         if (deq_cycles[1] - deq_cycles[0] < 3072) begin
            fail_cnt++;
            $display("FAIL b2b_gap: %0d cycles, required >= 3072", deq_cycles[1] - deq_cycles[0]);
         end
      end
   endtask

   // enable gating, then reset asserted mid-draw
   task automatic test_enable_reset();
      int n = 0;
      int stale = 0;
      enable = 1'b0; deq_cnt = 0; write_cnt = 0;
      push_cmd(1, 0, 0, 1);
      repeat (20) @(negedge sys_clock);
      assert_cnt++;
      if (deq_cnt !== 0 || busy !== 1'b0) begin
         fail_cnt++;
         $display("FAIL enable_low: %0d pulses busy %b, required 0 0", deq_cnt, busy);
      end
      enable = 1'b1;
      while (write_cnt < 40 && n < 2000) begin @(negedge sys_clock); n++; end
      assert_cnt++;
      if (write_cnt < 40) begin fail_cnt++; $display("FAIL midraw_start: %0d writes, required 40", write_cnt); end
      #2 sys_reset_n = 1'b0;
      #1;
      assert_cnt++;
      if ({bus.dequeue, bus.sprite_r_en, bus.fb_w_en, busy} !== 4'b0 || bus.sprite_r_addr !== '0 ||
          bus.fb_w_addr !== '0 || bus.fb_w_data !== 4'd0 || draws_done !== 16'd0) begin
         fail_cnt++;
         $display("FAIL async_reset: deq/ren/wen/busy %b raddr %0d waddr %0d wdata %0d draws %0d, required all 0",
                  {bus.dequeue, bus.sprite_r_en, bus.fb_w_en, busy}, bus.sprite_r_addr,
                  bus.fb_w_addr, bus.fb_w_data, draws_done);
      end
      exp_q.delete();
      repeat (2) @(negedge sys_clock);
      sys_reset_n = 1'b1;
      repeat (30) begin
         @(negedge sys_clock);
         if (bus.fb_w_en || busy) stale++;
      end
      assert_cnt++;
      if (stale !== 0 || draws_done !== 16'd0) begin
         fail_cnt++;
         $display("FAIL after_reset: %0d active cycles draws %0d, required 0 0", stale, draws_done);
      end
   endtask

   task automatic test_transparency();
`ifdef SPRITE_TRANSPARENCY_EN
      bit to;
      for (int i = 0; i < 1024; i++) mem[5 * 1024 + i] = 4'd0;
      write_cnt = 0;
      push_cmd(5, 0, 0, 1);
      wait_draws(16'd1, 4000, to);
      assert_cnt++;
      if (to || write_cnt !== 0 || draws_done !== 16'd1) begin
         fail_cnt++;
         $display("FAIL transparent: %0d writes draws %0d timeout %b, required 0 1",
                  write_cnt, draws_done, to);
      end
`endif
   endtask

   initial begin
      sys_reset_n = 1'b0;
      enable      = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cmd_id[i] = '0; cmd_x[i] = '0; cmd_y[i] = '0; cmd_s[i] = '0;
      end
      for (int i = 0; i < 16384; i++) mem[i] = 4'((i & 15) | 1);
      fork
         monitor_loop();
      join_none
      test_reset();
      test_basic();
      test_scale();
      test_clip();
      test_back_to_back();
      test_enable_reset();
      test_transparency();
      assert_cnt++;
      if (exp_q.size() != 0) begin
         fail_cnt++;
         $display("FAIL missing_writes: %0d left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end
endmodule
